// File: rtl/pkt_link_write.sv
// Ingress packet link writer: assigns a free buffer address to each block, chains them in the link-list SRAM
// and hands a packet descriptor to the read side. Optional statistics counters: define PKT_LINK_WRITE_STAT_EN.
module pkt_link_write #(
  parameter int ADDR_LENTH = 12,
  parameter int MAX_BLK    = 16,
  localparam int CNT_W     = $clog2(MAX_BLK)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [ADDR_LENTH-1:0] iEptyAddr,
  input  logic                  iEptyAddrVld,
  output logic                  oEptyAddrRdy,
  input  logic                  iBlkVld,
  output logic                  oBlkRdy,
  input  logic                  iBlkSop,
  input  logic                  iBlkEop,
  input  logic                  iBlkErr,
  output logic [ADDR_LENTH-1:0] oBlockAddr,
  output logic                  oBlockAddrVld,
  output logic [ADDR_LENTH-1:0] oWriteLaddr,
  output logic [ADDR_LENTH-1:0] oWriteLdata,
  output logic                  oWriteLaddrVld,
  output logic [ADDR_LENTH-1:0] oPktFirAddr,
  output logic                  oPktFirAddrVld,
  output logic [CNT_W-1:0]      oPktBlockNum,
  output logic                  oPktDrop,
  input  logic                  iPktFirAddrRdy,
  output logic                  oProtoErr,
  output logic [15:0]           oPktCnt,
  output logic [15:0]           oDropCnt
);

  // state | meaning
  // IDLE  | awaiting SOP
  // BODY  | mid-packet, linking blocks
  // TRUNC | packet overflowed, absorbing blocks until EOP
  // DESC  | descriptor presented, waiting for read side
  typedef enum logic [1:0] {IDLE, BODY, TRUNC, DESC} state_t;

  state_t                state, nextState;
  logic [ADDR_LENTH-1:0] firstAddr, prevAddr;
  logic [CNT_W-1:0]      blkCnt;
  logic                  dropFlag;
  logic                  overflow;
  logic                  blkAcc;
  logic                  descAcc;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // A block arriving with the counter already at MAX_BLK-1 has no room left in the
  // descriptor count, so it is never linked even when it carries EOP.
  always_comb begin
    nextState    = state;
    oBlkRdy      = 1'b0;
    oEptyAddrRdy = 1'b0;
    overflow     = 1'b0;
    case (state)
      IDLE: begin
        oBlkRdy      = iEptyAddrVld;
        oEptyAddrRdy = iBlkVld & iEptyAddrVld & iBlkSop;
        if (iBlkVld & iEptyAddrVld & iBlkSop)
          nextState = iBlkEop ? DESC : BODY;
      end
      BODY: begin
        overflow     = (blkCnt == CNT_W'(MAX_BLK - 1));
        oBlkRdy      = iEptyAddrVld;
        oEptyAddrRdy = iBlkVld & iEptyAddrVld & ~overflow;
        if (iBlkVld & iEptyAddrVld) begin
          if (iBlkEop)       nextState = DESC;
          else if (overflow) nextState = TRUNC;
        end
      end
      TRUNC: begin
        oBlkRdy = 1'b1;
        if (iBlkVld & iBlkEop) nextState = DESC;
      end
      DESC: begin
        if (iPktFirAddrRdy) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (iRst) begin
      oBlkRdy      = 1'b0;
      oEptyAddrRdy = 1'b0;
    end
  end

  assign blkAcc  = iBlkVld & oBlkRdy;
  assign descAcc = (state == DESC) & iPktFirAddrRdy;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      firstAddr      <= '0;
      prevAddr       <= '0;
      blkCnt         <= '0;
      dropFlag       <= 1'b0;
      oBlockAddr     <= '0;
      oBlockAddrVld  <= 1'b0;
      oWriteLaddr    <= '0;
      oWriteLdata    <= '0;
      oWriteLaddrVld <= 1'b0;
      oProtoErr      <= 1'b0;
    end else begin
      oBlockAddrVld  <= 1'b0;
      oWriteLaddrVld <= 1'b0;
      oProtoErr      <= 1'b0;
      case (state)
        IDLE: begin
          if (blkAcc) begin
            if (iBlkSop) begin
              firstAddr     <= iEptyAddr;
              prevAddr      <= iEptyAddr;
              blkCnt        <= '0;
              dropFlag      <= iBlkErr;
              oBlockAddr    <= iEptyAddr;
              oBlockAddrVld <= 1'b1;
            end else begin
              oProtoErr <= 1'b1;
            end
          end
        end
        BODY: begin
          if (blkAcc) begin
            dropFlag <= dropFlag | iBlkErr | iBlkSop | overflow;
            if (!overflow) begin
              blkCnt         <= blkCnt + CNT_W'(1);
              prevAddr       <= iEptyAddr;
              oBlockAddr     <= iEptyAddr;
              oBlockAddrVld  <= 1'b1;
              oWriteLaddr    <= prevAddr;
              oWriteLdata    <= iEptyAddr;
              oWriteLaddrVld <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign oPktFirAddrVld = (state == DESC);
  assign oPktFirAddr    = firstAddr;
  assign oPktBlockNum   = blkCnt;
  assign oPktDrop       = dropFlag;

`ifdef PKT_LINK_WRITE_STAT_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oPktCnt  <= '0;
      oDropCnt <= '0;
    end else if (descAcc) begin
      if (!dropFlag && oPktCnt != 16'hFFFF)  oPktCnt  <= oPktCnt + 16'd1;
      if (dropFlag && oDropCnt != 16'hFFFF)  oDropCnt <= oDropCnt + 16'd1;
    end
  end
`else
  assign oPktCnt  = '0;
  assign oDropCnt = '0;
`endif

endmodule
